td4_prog_loader: RTL and testbench

Writer side of the TD4 program memory: a 16 x 8 program RAM that a host fills byte-by-byte over a valid/ready stream. The CPU reads it combinationally by PC address. The block holds the CPU in reset while a program is loading and releases it only after a framed, checksummed load completes.

---
 rtl/td4_prog_loader.sv | 153 +++++++++++++++
 tb/tb_td4_prog_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/td4_prog_loader.sv
// TD4 program memory writer: a 16 x 8 RAM filled from a framed, checksummed byte stream.
// The CPU reads the RAM combinationally and is held in reset until a load succeeds.
module td4_prog_loader #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          cpu_reset_n,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [DW-1:0] Header = DW'(8'hA5);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StClear,
    StData,
    StCksum,
    StDone,
    StErr
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] cptr_q, cptr_d;
  logic [DW-1:0] sum_q, sum_d;

  logic [DW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic accept;
  logic len_ok;

  assign rx_ready = (state_q != StClear);
  assign accept   = rx_valid && rx_ready;
  assign len_ok   = (rx_data != '0) && (32'(rx_data) <= DEPTH);
  assign rd_data  = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      wptr_q  <= '0;
      cptr_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wptr_q  <= wptr_d;
      cptr_q  <= cptr_d;
      sum_q   <= sum_d;
    end
  end

  // RAM contents deliberately survive reset; a write in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wptr_d      = wptr_q;
    cptr_d      = cptr_q;
    sum_d       = sum_q;
    mem_we      = 1'b0;
    mem_waddr   = wptr_q;
    mem_wdata   = rx_data;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    cpu_reset_n = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept && rx_data == Header) begin
          state_d = StLen;
        end
      end
      StLen: begin
        busy = 1'b1;
        if (accept) begin
          if (len_ok) begin
            len_d   = rx_data[AW:0];
            wptr_d  = '0;
            cptr_d  = '0;
            sum_d   = '0;
            state_d = StClear;
          end else begin
            state_d = StErr;
          end
        end
      end
      StClear: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = cptr_q;
        mem_wdata = '0;
        cptr_d    = cptr_q + 1'b1;
        if (cptr_q == AW'(DEPTH - 1)) begin
          state_d = StData;
        end
      end
      StData: begin
        busy = 1'b1;
        if (accept) begin
          mem_we = 1'b1;
          sum_d  = sum_q + rx_data;
          wptr_d = wptr_q + 1'b1;
          if ({1'b0, wptr_q} == len_q - 1'b1) begin
            state_d = StCksum;
          end
        end
      end
      StCksum: begin
        busy = 1'b1;
        if (accept) begin
          state_d = (rx_data == sum_q) ? StDone : StErr;
        end
      end
      StDone: begin
        done        = 1'b1;
        cpu_reset_n = 1'b1;
        if (accept && rx_data == Header) begin
          state_d = StLen;
        end
      end
      StErr: begin
        err = 1'b1;
        if (accept && rx_data == Header) begin
          state_d = StLen;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Self-checking bench for td4_prog_loader: table of frames with expected status and RAM
// image, a status scoreboard, and hand-written reset / reload sequences.
module tb_td4_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       cpu_reset_n;
  logic       busy;
  logic       done;
  logic       err;

  td4_prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cpu_reset_n(cpu_reset_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // bytes: first byte in the top octet; words: expected RAM[0..3], top octet is address 0
  typedef struct {
    logic [63:0] bytes;
    int          n;
    int          hold_idx;
    logic        exp_done;
    logic        exp_err;
    int          exp_clr;
    bit          chk_mem;
    logic [31:0] words;
  } row_t;

  typedef struct {
    logic done;
    logic err;
    logic rstn;
    int   clr;
  } exp_t;

  row_t rows [8];
  exp_t sb [$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   clr_cnt = 0;

  always @(negedge clk) begin
    if (!rx_ready) clr_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    budget   = 0;
    while (!rx_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) begin
      chk("handshake_timeout", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic set_row(input int r, input logic [63:0] bytes, input int n, input int hold_idx,
                         input logic d, input logic e, input int clr, input bit cm,
                         input logic [31:0] words);
    rows[r].bytes    = bytes;
    rows[r].n        = n;
    rows[r].hold_idx = hold_idx;
    rows[r].exp_done = d;
    rows[r].exp_err  = e;
    rows[r].exp_clr  = clr;
    rows[r].chk_mem  = cm;
    rows[r].words    = words;
  endtask

  task automatic check_mem(input string tag, input logic [31:0] words);
    logic [7:0] exp;
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      exp = (a < 4) ? words[31-8*a -: 8] : 8'h00;
      chk($sformatf("%s_mem%0d", tag, a), 32'(rd_data), 32'(exp));
    end
  endtask

  task automatic run_row(input int r, input bit gaps);
    exp_t e, got;
    string tag;
    tag    = $sformatf("row%0d_g%0d", r, gaps);
    e.done = rows[r].exp_done;
    e.err  = rows[r].exp_err;
    e.rstn = rows[r].exp_done;
    e.clr  = rows[r].exp_clr;
    sb.push_back(e);
    clr_cnt = 0;
    for (int i = 0; i < rows[r].n; i++) begin
      send(rows[r].bytes[63-8*i -: 8], gaps);
      if (i == rows[r].hold_idx) begin
        chk({tag, "_hdr_busy"}, 32'(busy), 32'd1);
        chk({tag, "_hdr_rstn"}, 32'(cpu_reset_n), 32'd0);
        chk({tag, "_hdr_done"}, 32'(done), 32'd0);
        chk({tag, "_hdr_err"}, 32'(err), 32'd0);
      end
    end
    got = sb.pop_front();
    chk({tag, "_done"}, 32'(done), 32'(got.done));
    chk({tag, "_err"}, 32'(err), 32'(got.err));
    chk({tag, "_rstn"}, 32'(cpu_reset_n), 32'(got.rstn));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_clear_cycles"}, 32'(clr_cnt), 32'(got.clr));
    if (rows[r].chk_mem) check_mem(tag, rows[r].words);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rstn"}, 32'(cpu_reset_n), 32'd0);
  endtask

  initial begin
    set_row(0, 64'hA5_03_31_42_7F_F2_00_00, 6, 0, 1'b1, 1'b0, 16, 1'b1, 32'h31_42_7F_00);
    set_row(1, 64'hA5_03_31_42_7F_F3_00_00, 6, 0, 1'b0, 1'b1, 16, 1'b1, 32'h31_42_7F_00);
    set_row(2, 64'hA5_03_31_42_7F_F2_00_00, 6, 0, 1'b1, 1'b0, 16, 1'b1, 32'h31_42_7F_00);
    set_row(3, 64'hA5_00_00_00_00_00_00_00, 2, 0, 1'b0, 1'b1, 0, 1'b1, 32'h31_42_7F_00);
    set_row(4, 64'hA5_11_00_00_00_00_00_00, 2, 0, 1'b0, 1'b1, 0, 1'b1, 32'h31_42_7F_00);
    set_row(5, 64'h00_12_A5_03_31_42_7F_F2, 8, 2, 1'b1, 1'b0, 16, 1'b1, 32'h31_42_7F_00);
    set_row(6, 64'hA5_01_10_10_00_00_00_00, 4, 0, 1'b1, 1'b0, 16, 1'b1, 32'h10_00_00_00);
    set_row(7, 64'hA5_02_A5_33_D8_00_00_00, 5, 0, 1'b1, 1'b0, 16, 1'b1, 32'hA5_33_00_00);

    // Reset with a header on the bus: the byte must be lost.
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    rd_addr  = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    check_idle("reset");

    for (int g = 0; g < 2; g++) begin
      for (int r = 0; r < 8; r++) run_row(r, g[0]);

      // Reset after the second data byte, then a fresh frame.
      send(8'hA5, g[0]);
      send(8'h03, g[0]);
      send(8'h31, g[0]);
      send(8'h42, g[0]);
      chk($sformatf("midload_g%0d_busy_before", g), 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_idle($sformatf("midload_g%0d", g));
      run_row(0, g[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
